// File: rtl/masked_subbytes_seq.sv
// Sequencer for 4-share masked SubBytes: slices the state into NUM_SBOX-byte groups, feeds an
// external S-box array with fresh randomness and reassembles the shared result for a consumer.
module masked_subbytes_seq #(
    parameter int NUM_SBOX = 4,
    parameter int SBOX_LAT = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           state_in0,
    input  logic [127:0]           state_in1,
    input  logic [127:0]           state_in2,
    input  logic [127:0]           state_in3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           state_out0,
    output logic [127:0]           state_out1,
    output logic [127:0]           state_out2,
    output logic [127:0]           state_out3,
    input  logic [28*NUM_SBOX-1:0] rnd,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    output logic [8*NUM_SBOX-1:0]  sb_in0,
    output logic [8*NUM_SBOX-1:0]  sb_in1,
    output logic [8*NUM_SBOX-1:0]  sb_in2,
    output logic [8*NUM_SBOX-1:0]  sb_in3,
    output logic [28*NUM_SBOX-1:0] sb_r,
    input  logic [8*NUM_SBOX-1:0]  sb_out0,
    input  logic [8*NUM_SBOX-1:0]  sb_out1,
    input  logic [8*NUM_SBOX-1:0]  sb_out2,
    input  logic [8*NUM_SBOX-1:0]  sb_out3
);
    localparam int NB = 8 * NUM_SBOX;
    localparam int G  = 16 / NUM_SBOX;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0] LAST_G = GW'(G - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
    typedef logic [G-1:0][NB-1:0] grouped_t;

    state_t              state;
    logic [GW-1:0]       grp;
    grouped_t            buf_q     [4];
    grouped_t            res_q     [4];
    grouped_t            shares_in [4];
    logic [NB-1:0]       sb_in_w   [4];
    logic [NB-1:0]       sb_out_w  [4];
    logic [SBOX_LAT-1:0] tag_vld;
    logic [GW-1:0]       tag_grp   [SBOX_LAT];
    logic                issue;
    logic                pend;

    assign shares_in[0] = state_in0;
    assign shares_in[1] = state_in1;
    assign shares_in[2] = state_in2;
    assign shares_in[3] = state_in3;
    assign sb_out_w[0]  = sb_out0;
    assign sb_out_w[1]  = sb_out1;
    assign sb_out_w[2]  = sb_out2;
    assign sb_out_w[3]  = sb_out3;

    assign issue     = (state == FEED) && rnd_valid;
    assign rnd_ready = issue;
    assign sb_r      = issue ? rnd : '0;

    // Bubbles drive zeros so a stalled round never leaks stale shares into the S-boxes.
    always_comb begin
        for (int k = 0; k < 4; k++) sb_in_w[k] = issue ? buf_q[k][grp] : '0;
        // Entries still in flight after this edge; the last stage retires at this edge.
        pend = 1'b0;
        for (int i = 0; i < SBOX_LAT - 1; i++) pend = pend | tag_vld[i];
    end

    assign sb_in0     = sb_in_w[0];
    assign sb_in1     = sb_in_w[1];
    assign sb_in2     = sb_in_w[2];
    assign sb_in3     = sb_in_w[3];
    assign state_out0 = res_q[0];
    assign state_out1 = res_q[1];
    assign state_out2 = res_q[2];
    assign state_out3 = res_q[3];

    // NOTE: the wide share buffers are reset too, so no share material survives a mid-operation reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            grp       <= '0;
            tag_vld   <= '0;
            for (int i = 0; i < SBOX_LAT; i++) tag_grp[i] <= '0;
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            tag_vld[0] <= issue;
            tag_grp[0] <= grp;
            for (int i = 1; i < SBOX_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_grp[i] <= tag_grp[i-1];
            end
            if (tag_vld[SBOX_LAT-1]) begin
                for (int k = 0; k < 4; k++) res_q[k][tag_grp[SBOX_LAT-1]] <= sb_out_w[k];
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 4; k++) buf_q[k] <= shares_in[k];
                        grp      <= '0;
                        in_ready <= 1'b0;
                        state    <= FEED;
                    end
                end
                FEED: begin
                    if (issue) begin
                        grp <= grp + 1'b1;
                        if (grp == LAST_G) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pend) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Self-checking bench: three sequencers (NUM_SBOX = 4, 16, 1) each drive a behavioural masked
// S-box and are checked every cycle against a transaction-level model of the SubBytes round.
module tb_masked_subbytes_seq;
    localparam int SBOX_LAT = 2;

    logic clk;
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // AES S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] p = x;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] y = '0;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = aes_sbox(x[8*i +: 8]);
        return y;
    endfunction

    // Output shares of the modelled S-box: three shares straight from randomness, share 0 completes it.
    function automatic logic [31:0] sbox_shares(input logic [7:0] x, input logic [27:0] r);
        return {r[23:16], r[15:8], r[7:0], aes_sbox(x) ^ r[7:0] ^ r[15:8] ^ r[23:16]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int NS      = (gi == 0) ? 4 : ((gi == 1) ? 16 : 1);
        localparam int G       = 16 / NS;
        localparam int NB      = 8 * NS;
        localparam int LAT_LIT = (gi == 0) ? 7 : ((gi == 1) ? 4 : 19);

        logic            rst_n, in_valid, in_ready, out_valid, out_ready, rnd_valid, rnd_ready;
        logic [127:0]    st_in  [4];
        logic [127:0]    st_out [4];
        logic [28*NS-1:0] rnd, sb_r;
        logic [NB-1:0]   sb_in  [4];
        logic [NB-1:0]   sbm_d  [4];
        logic [NB-1:0]   sbm_p1 [4];
        logic [NB-1:0]   sbm_p2 [4];
        bit              done;

        masked_subbytes_seq #(.NUM_SBOX(NS), .SBOX_LAT(SBOX_LAT)) dut (
            .CLK(clk), .RST_N(rst_n),
            .in_valid(in_valid), .in_ready(in_ready),
            .state_in0(st_in[0]), .state_in1(st_in[1]), .state_in2(st_in[2]), .state_in3(st_in[3]),
            .out_valid(out_valid), .out_ready(out_ready),
            .state_out0(st_out[0]), .state_out1(st_out[1]),
            .state_out2(st_out[2]), .state_out3(st_out[3]),
            .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
            .sb_in0(sb_in[0]), .sb_in1(sb_in[1]), .sb_in2(sb_in[2]), .sb_in3(sb_in[3]),
            .sb_r(sb_r),
            .sb_out0(sbm_p2[0]), .sb_out1(sbm_p2[1]), .sb_out2(sbm_p2[2]), .sb_out3(sbm_p2[3])
        );

        // Behavioural two-stage S-box array; deliberately never reset.
        always_comb begin
            logic [31:0] sh;
            sh = '0;
            for (int k = 0; k < 4; k++) sbm_d[k] = '0;
            for (int j = 0; j < NS; j++) begin
                sh = sbox_shares(sb_in[0][8*j +: 8] ^ sb_in[1][8*j +: 8] ^ sb_in[2][8*j +: 8]
                                 ^ sb_in[3][8*j +: 8], sb_r[28*j +: 28]);
                for (int k = 0; k < 4; k++) sbm_d[k][8*j +: 8] = sh[8*k +: 8];
            end
        end

        always @(posedge clk) begin
            sbm_p1 <= sbm_d;
            sbm_p2 <= sbm_p1;
        end

        // Transaction model: one state in flight; groups consumed in order, one per rnd_valid.
        logic [127:0] m_buf [4];
        logic [127:0] m_exp [4];
        logic [127:0] m_pt;
        int           m_issued, m_ov_cyc, cyc;
        bit           m_busy, m_feed;

        initial begin
            bit          idle, exp_issue, exp_ov;
            logic [31:0] sh;
            int          b;
            m_busy = 0; m_feed = 0; m_issued = 0; m_ov_cyc = 0; cyc = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst_n) begin
                    m_busy = 0;
                    m_feed = 0;
                end else begin
                    idle      = !m_busy;
                    exp_issue = m_feed && rnd_valid;
                    check($sformatf("n%0d_in_ready", NS), 512'(in_ready), 512'(idle));
                    check($sformatf("n%0d_rnd_ready", NS), 512'(rnd_ready), 512'(exp_issue));
                    if (exp_issue) begin
                        for (int k = 0; k < 4; k++)
                            check($sformatf("n%0d_sb_in%0d", NS, k), 512'(sb_in[k]),
                                  512'(m_buf[k][m_issued*NB +: NB]));
                        check($sformatf("n%0d_sb_r", NS), 512'(sb_r), 512'(rnd));
                        for (int j = 0; j < NS; j++) begin
                            b  = m_issued * NS + j;
                            sh = sbox_shares(m_pt[8*b +: 8], rnd[28*j +: 28]);
                            for (int k = 0; k < 4; k++) m_exp[k][8*b +: 8] = sh[8*k +: 8];
                        end
                        m_issued++;
                        if (m_issued == G) begin
                            m_feed   = 0;
                            m_ov_cyc = cyc + SBOX_LAT + 1;
                        end
                    end else if (m_feed) begin
                        for (int k = 0; k < 4; k++)
                            check($sformatf("n%0d_bubble_sb_in%0d", NS, k), 512'(sb_in[k]), 512'(0));
                        check($sformatf("n%0d_bubble_sb_r", NS), 512'(sb_r), 512'(0));
                    end
                    exp_ov = m_busy && !m_feed && (cyc >= m_ov_cyc);
                    check($sformatf("n%0d_out_valid", NS), 512'(out_valid), 512'(exp_ov));
                    if (exp_ov) begin
                        for (int k = 0; k < 4; k++)
                            check($sformatf("n%0d_state_out%0d", NS, k), 512'(st_out[k]), 512'(m_exp[k]));
                        check($sformatf("n%0d_recombined", NS),
                              512'(st_out[0] ^ st_out[1] ^ st_out[2] ^ st_out[3]), 512'(sub_bytes(m_pt)));
                        if (out_ready) m_busy = 0;
                    end
                    if (idle && in_valid) begin
                        m_busy   = 1;
                        m_feed   = 1;
                        m_issued = 0;
                        m_buf    = st_in;
                        m_pt     = st_in[0] ^ st_in[1] ^ st_in[2] ^ st_in[3];
                    end
                end
            end
        end

        task automatic chk_reset(input string tag);
            check($sformatf("n%0d_%s_in_ready", NS, tag), 512'(in_ready), 512'(1));
            check($sformatf("n%0d_%s_out_valid", NS, tag), 512'(out_valid), 512'(0));
            check($sformatf("n%0d_%s_rnd_ready", NS, tag), 512'(rnd_ready), 512'(0));
            check($sformatf("n%0d_%s_sb_r", NS, tag), 512'(sb_r), 512'(0));
            for (int k = 0; k < 4; k++) begin
                check($sformatf("n%0d_%s_state_out%0d", NS, tag, k), 512'(st_out[k]), 512'(0));
                check($sformatf("n%0d_%s_sb_in%0d", NS, tag, k), 512'(sb_in[k]), 512'(0));
            end
        endtask

        // mode 0: rnd_valid always 1, mode 1: 1,0,1,0..., mode 2: random. rst_at > 0 aborts with reset.
        task automatic run(input logic [127:0] pt, input bit z0, input int mode, input int stall,
                           input int rst_at, output logic [127:0] res, output int lat);
            logic [127:0] s [4];
            int  issued  = 0;
            int  exp_lat = 0;
            bit  aborted = 0;
            lat = -1;
            res = '0;
            s[0] = z0 ? 128'h0 : rand128();
            s[1] = rand128();
            s[2] = rand128();
            s[3] = pt ^ s[0] ^ s[1] ^ s[2];
            st_in    = s;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int k = 0; k < 4; k++) st_in[k] = rand128();
            for (int k = 1; k < 200; k++) begin
                if (out_valid) begin
                    lat = k;
                    break;
                end
                if (k == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk_reset("midreset");
                    @(posedge clk); #1;
                    rst_n     = 1'b1;
                    rnd_valid = 1'b0;
                    @(posedge clk); #1;
                    aborted = 1;
                    break;
                end
                case (mode)
                    0:       rnd_valid = 1'b1;
                    1:       rnd_valid = k[0];
                    default: rnd_valid = ($urandom_range(0, 1) == 1);
                endcase
                for (int j = 0; j < NS; j++) rnd[28*j +: 28] = 28'($urandom);
                if (rnd_valid && issued < G) begin
                    issued++;
                    if (issued == G) exp_lat = k + SBOX_LAT + 1;
                end
                @(posedge clk); #1;
            end
            if (!aborted) begin
                check($sformatf("n%0d_latency", NS), 512'(lat), 512'(exp_lat));
                res = st_out[0] ^ st_out[1] ^ st_out[2] ^ st_out[3];
                check($sformatf("n%0d_result", NS), 512'(res), 512'(sub_bytes(pt)));
                repeat (stall) begin @(posedge clk); #1; end
                out_ready = 1'b1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                check($sformatf("n%0d_idle_after_handshake", NS), 512'(in_ready), 512'(1));
            end
        endtask

        initial begin
            logic [127:0] res, pt;
            int           lat;
            rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rnd_valid = 1'b0; rnd = '0;
            for (int k = 0; k < 4; k++) st_in[k] = '0;
            repeat (3) @(posedge clk);
            #1;
            chk_reset("reset");
            rst_n = 1'b1;
            @(posedge clk); #1;

            run(128'h0, 1'b1, 0, 0, 0, res, lat);
            check($sformatf("n%0d_zero_state", NS), 512'(res), 512'({16{8'h63}}));
            check($sformatf("n%0d_latency_literal", NS), 512'(lat), 512'(LAT_LIT));

            run(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0, 0, 0, 0, res, lat);
            check($sformatf("n%0d_bytes_00_0f", NS), 512'(res),
                  512'(128'h76abd7fe_2b670130_c56f6bf2_7b777c63));

            run(rand128(), 1'b0, 1, 0, 0, res, lat);
            check($sformatf("n%0d_toggle_latency", NS), 512'(lat), 512'(2 * G + 2));

            run(rand128(), 1'b0, 0, 5, 0, res, lat);
            run(rand128(), 1'b0, 0, 0, 3, res, lat);
            run(rand128(), 1'b0, 2, 1, 0, res, lat);

            run({16{8'h53}}, 1'b0, 0, 0, 0, res, lat);
            check($sformatf("n%0d_all_53", NS), 512'(res), 512'({16{8'hed}}));

            for (int n = 0; n < 6; n++) begin
                pt = rand128();
                run(pt, 1'b0, 2, $urandom_range(0, 3), 0, res, lat);
            end
            done = 1'b1;
        end
    end

    initial begin
        check("model_sbox_53", 512'(aes_sbox(8'h53)), 512'(8'hed));
        wait (g_dut[0].done && g_dut[1].done && g_dut[2].done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/masked_subbytes_seq.md
Name: masked_subbytes_seq

Overview:
- Sequences a full 128-bit, 4-share masked AES state through NUM_SBOX parallel instances of the team's two-stage 4-share S-box (2-cycle latency, 28 random bits per instance per cycle).
- Sits directly upstream and downstream of the S-box array. It slices the state into byte groups, issues them with fresh randomness, tracks in-flight groups, and reassembles the shared SubBytes result behind a valid/ready handshake.
- Does not instantiate the S-boxes. Their ports are exposed so the round datapath can share them.

Parameters:
- NUM_SBOX, 4, S-box instances driven per cycle. Legal values: 1, 2, 4, 8, 16.
- SBOX_LAT, 2, S-box pipeline latency in cycles. Must match the instantiated S-box.

Ports:
- CLK  input  1  clock; all flops rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  state_in* valid.
- in_ready  output  1  block can accept a state.
- state_in0..state_in3  input  128 each  input shares; byte i = bits [8i+7:8i].
- out_valid  output  1  state_out* valid.
- out_ready  input  1  consumer accepts the output.
- state_out0..state_out3  output  128 each  SubBytes result shares.
- rnd  input  28*NUM_SBOX  fresh randomness.
- rnd_valid  input  1  rnd is usable this cycle.
- rnd_ready  output  1  rnd consumed this cycle; equals issue.
- sb_in0..sb_in3  output  8*NUM_SBOX each  S-box input shares; instance j uses bits [8j+7:8j].
- sb_r  output  28*NUM_SBOX  S-box randomness; instance j uses bits [28j+27:28j].
- sb_out0..sb_out3  input  8*NUM_SBOX each  S-box output shares.

Behaviour:
- Reset (async assert, sync deassert):
  - State returns to IDLE; group counter and tag pipe cleared.
  - in_ready=1, out_valid=0, rnd_ready=0.
  - state_out* = 0; sb_in* = 0; sb_r = 0.
- Reset asserted mid-operation discards all in-flight groups. S-box pipeline contents left over after reset are ignored because all tags are 0.
- FSM, with G = 16/NUM_SBOX groups:
  - IDLE: in_ready=1. On in_valid, latch state_in0..3 into the input buffer, clear the group counter, and go to FEED.
  - FEED: issue = rnd_valid.
    - On issue: sb_in* = buffer bytes [g*NUM_SBOX, g*NUM_SBOX+NUM_SBOX-1], sb_r = rnd, rnd_ready=1, and g increments.
    - Without issue: sb_in* = 0, sb_r = 0, and no tag is pushed (bubble).
    - After the issue with g=G-1, go to DRAIN.
  - DRAIN: no issue; wait until the tag pipe is empty, then go to DONE.
  - DONE: out_valid=1. state_out* held stable until out_valid && out_ready. On that handshake go to IDLE with out_valid=0.
- Tag pipe:
  - SBOX_LAT-deep shift register carrying {valid, group index}.
  - An entry pushed in issue cycle c emerges in cycle c+SBOX_LAT. In that cycle, sb_out0..3 are written into state_out0..3 bytes of that group at the clock edge.
- in_ready=0 in FEED, DRAIN and DONE. There is no overlap of consecutive states, so each state is fully written before out_valid.
- Issue requires both FEED and rnd_valid. rnd_ready is never 1 outside FEED, so randomness is never consumed without use.
- Share separation: shares are never XORed together inside this block. Each sb_in share k is driven only from buffer share k, and each state_out share k only from sb_out share k.
- Latency with rnd_valid held high:
  - Accept edge at cycle t.
  - Issues in cycles t+1..t+G.
  - out_valid rises in cycle t+G+SBOX_LAT+1, i.e. t+7 for the defaults.
- Each cycle of rnd_valid=0 during FEED adds exactly one cycle to latency.

Test Plan:
- Defaults with real S-boxes, rnd_valid=1, state_in0 = 128'h0, other shares random but XORing to 0 -> XOR of the out shares = 16 bytes of 8'h63; out_valid exactly 7 cycles after accept; rnd_ready high for exactly 4 cycles.
- Plaintext bytes 00..0f split into 4 random shares -> recombined output = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76 (byte0 = 63).
- rnd_valid toggled 1,0,1,0,... during FEED -> 4 issues spread over 7 cycles; sb_in*=0 and sb_r=0 in bubble cycles; correct output; out_valid at accept+10.
- out_ready held 0 for 5 cycles in DONE -> out_valid and state_out* stable; in_ready stays 0; after the handshake, IDLE with in_ready=1 next cycle.
- RST_N pulsed low in cycle accept+3 -> outputs immediately show reset values; a new state accepted after reset produces correct results uncorrupted by stale pipeline data.
- NUM_SBOX=16 and NUM_SBOX=1 with input byte 8'h53 in all bytes -> recombined output 8'hed everywhere; latency 4 and 19 cycles respectively.
